// File: rtl/cmp_score_tracker.sv
// Frame-based tally of 2-bit comparator gt/eq/lt flags with longest A>B run.
// One result record per frame is offered through a valid/ready handshake.
module cmp_score_tracker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] max_gt_run,
    output logic [1:0]       verdict,
    output logic [CNT_W-1:0] bad_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    typedef enum logic [1:0] {
        S_GT,
        S_EQ,
        S_LT,
        S_BAD
    } sample_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] gt_q;
    logic [CNT_W-1:0] gt_d;
    logic [CNT_W-1:0] eq_q;
    logic [CNT_W-1:0] eq_d;
    logic [CNT_W-1:0] lt_q;
    logic [CNT_W-1:0] lt_d;
    logic [CNT_W-1:0] bad_q;
    logic [CNT_W-1:0] bad_d;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_d;
    logic [CNT_W-1:0] max_q;
    logic [CNT_W-1:0] max_d;
    logic [CNT_W-1:0] tot_q;
    logic [CNT_W-1:0] tot_d;

    sample_t          sample;
    logic             accept;
    logic             legal;
    logic             clear;
    logic             frame_done;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] tot_inc;

    // Handshake flags follow the state directly so reset clears them too.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == REPORT);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        sample = S_BAD;
        case ({gt, eq, lt})
            3'b100:  sample = S_GT;
            3'b010:  sample = S_EQ;
            3'b001:  sample = S_LT;
            default: sample = S_BAD;
        endcase
    end

    assign legal      = (sample != S_BAD);
    assign run_inc    = run_q + 1'b1;
    assign tot_inc    = tot_q + 1'b1;
    assign frame_done = accept && legal && (tot_inc == FRAME_LEN_C);

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (frame_done) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gt_d  = gt_q;
        eq_d  = eq_q;
        lt_d  = lt_q;
        bad_d = bad_q;
        run_d = run_q;
        max_d = max_q;
        tot_d = tot_q;
        if (clear) begin
            gt_d  = '0;
            eq_d  = '0;
            lt_d  = '0;
            bad_d = '0;
            run_d = '0;
            max_d = '0;
            tot_d = '0;
        end else if (accept) begin
            // Illegal samples only bump bad_cnt; they leave the run intact.
            case (sample)
                S_GT: begin
                    gt_d  = gt_q + 1'b1;
                    run_d = run_inc;
                    max_d = (run_inc > max_q) ? run_inc : max_q;
                    tot_d = tot_inc;
                end
                S_EQ: begin
                    eq_d  = eq_q + 1'b1;
                    run_d = '0;
                    tot_d = tot_inc;
                end
                S_LT: begin
                    lt_d  = lt_q + 1'b1;
                    run_d = '0;
                    tot_d = tot_inc;
                end
                default: begin
                    bad_d = (bad_q == CNT_MAX) ? bad_q : bad_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gt_q    <= '0;
            eq_q    <= '0;
            lt_q    <= '0;
            bad_q   <= '0;
            run_q   <= '0;
            max_q   <= '0;
            tot_q   <= '0;
        end else begin
            state_q <= state_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            bad_q   <= bad_d;
            run_q   <= run_d;
            max_q   <= max_d;
            tot_q   <= tot_d;
        end
    end

    assign gt_cnt     = gt_q;
    assign eq_cnt     = eq_q;
    assign lt_cnt     = lt_q;
    assign bad_cnt    = bad_q;
    assign max_gt_run = max_q;

    always_comb begin
        verdict = 2'b00;
        if (gt_q > lt_q) begin
            verdict = 2'b01;
        end else if (lt_q > gt_q) begin
            verdict = 2'b10;
        end
    end

endmodule

// File: tb/tb_cmp_score_tracker.sv
// Directed bench for cmp_score_tracker with a sample-list reference model.
// The model keeps the accepted legal samples and derives every count from them.
module tb_cmp_score_tracker;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] max_gt_run;
    logic [1:0]       verdict;
    logic [CNT_W-1:0] bad_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;

    cmp_score_tracker #(
        .FRAME_LEN(FRAME_LEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .gt(gt),
        .eq(eq),
        .lt(lt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .gt_cnt(gt_cnt),
        .eq_cnt(eq_cnt),
        .lt_cnt(lt_cnt),
        .max_gt_run(max_gt_run),
        .verdict(verdict),
        .bad_cnt(bad_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 collecting, 2 reporting; m_q holds legal samples
    // (0 gt, 1 eq, 2 lt) of the current or last frame.
    int m_phase = 0;
    int m_q[$];
    int m_bad = 0;

    function automatic int m_cnt(input int code);
        int n = 0;
        foreach (m_q[i]) if (m_q[i] == code) n++;
        return n;
    endfunction

    function automatic int m_run();
        int best = 0;
        int cur = 0;
        foreach (m_q[i]) begin
            if (m_q[i] == 0) begin
                cur++;
                if (cur > best) best = cur;
            end else begin
                cur = 0;
            end
        end
        return best;
    endfunction

    function automatic int m_verdict();
        int g = m_cnt(0);
        int l = m_cnt(2);
        if (g > l) return 1;
        if (l > g) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            m_bad = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_q.delete();
                m_bad = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                if (int'(gt) + int'(eq) + int'(lt) == 1)
                    m_q.push_back(gt ? 0 : (eq ? 1 : 2));
                else if (m_bad < (1 << CNT_W) - 1)
                    m_bad++;
                if (m_q.size() == FRAME_LEN) m_phase = 2;
            end
        end else begin
            if (out_ready) m_phase = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_phase == 1));
        chk("out_valid", int'(out_valid), int'(m_phase == 2));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("gt_cnt", int'(gt_cnt), m_cnt(0));
        chk("eq_cnt", int'(eq_cnt), m_cnt(1));
        chk("lt_cnt", int'(lt_cnt), m_cnt(2));
        chk("max_gt_run", int'(max_gt_run), m_run());
        chk("bad_cnt", int'(bad_cnt), m_bad);
        if (m_phase == 2) chk("verdict", int'(verdict), m_verdict());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // 0 gt, 1 eq, 2 lt, 3 gt+eq (illegal), 4 none (illegal)
    task automatic send(input int c);
        in_valid = 1'b1;
        case (c)
            0: {gt, eq, lt} = 3'b100;
            1: {gt, eq, lt} = 3'b010;
            2: {gt, eq, lt} = 3'b001;
            3: {gt, eq, lt} = 3'b110;
            default: {gt, eq, lt} = 3'b000;
        endcase
        tick();
        in_valid = 1'b0;
        {gt, eq, lt} = 3'b000;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, int'(out_valid), 1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_record(input string tag, input int g, input int e,
                                input int l, input int r, input int v,
                                input int b);
        chk({tag, "_gt"}, int'(gt_cnt), g);
        chk({tag, "_eq"}, int'(eq_cnt), e);
        chk({tag, "_lt"}, int'(lt_cnt), l);
        chk({tag, "_run"}, int'(max_gt_run), r);
        chk({tag, "_verdict"}, int'(verdict), v);
        chk({tag, "_bad"}, int'(bad_cnt), b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mixed[8] = '{0, 0, 0, 1, 0, 2, 0, 0};
        int illeg[10] = '{0, 0, 3, 4, 0, 1, 2, 2, 1, 0};
        int fresh[8] = '{1, 2, 0, 0, 1, 1, 2, 0};
        logic [CNT_W-1:0] snap_gt;
        logic [CNT_W-1:0] snap_lt;
        logic [1:0] snap_v;

        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        {gt, eq, lt} = 3'b000;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_record("reset", 0, 0, 0, 0, 0, 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);

        send(0);
        chk("idle_in_ready", int'(in_ready), 0);
        chk("idle_gt_cnt", int'(gt_cnt), 0);

        do_start();
        foreach (mixed[i]) send(mixed[i]);
        chk("mixed_latency", int'(out_valid), 1);
        chk("mixed_model_gt", m_cnt(0), 6);
        chk("mixed_model_run", m_run(), 3);
        check_record("mixed", 6, 1, 1, 3, 1, 0);
        accept();
        tick();

        do_start();
        repeat (8) send(1);
        wait_valid("tie_wait");
        chk("tie_model_verdict", m_verdict(), 0);
        check_record("tie", 0, 8, 0, 0, 0, 0);
        accept();
        tick();

        do_start();
        repeat (5) send(2);
        repeat (3) send(0);
        wait_valid("bwin_wait");
        check_record("bwin", 3, 0, 5, 3, 2, 0);
        snap_gt = gt_cnt;
        snap_lt = lt_cnt;
        snap_v = verdict;
        out_ready = 1'b0;
        in_valid = 1'b1;
        {gt, eq, lt} = 3'b100;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            tick();
        end
        start = 1'b0;
        chk("hold_gt", int'(gt_cnt), int'(snap_gt));
        chk("hold_lt", int'(lt_cnt), int'(snap_lt));
        chk("hold_verdict", int'(verdict), int'(snap_v));
        chk("hold_in_ready", int'(in_ready), 0);
        chk("hold_out_valid", int'(out_valid), 1);
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        {gt, eq, lt} = 3'b000;
        chk("ack_busy", int'(busy), 0);
        chk("ack_out_valid", int'(out_valid), 0);
        tick();
        chk("ack_no_restart", int'(busy), 0);
        chk("idle_keeps_lt", int'(lt_cnt), 5);

        do_start();
        foreach (illeg[i]) begin
            send(illeg[i]);
            if (i == 8) chk("illeg_not_done", int'(out_valid), 0);
        end
        chk("illeg_latency", int'(out_valid), 1);
        check_record("illeg", 4, 2, 2, 3, 1, 2);
        accept();
        tick();

        do_start();
        repeat (4) send(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_record("midrst", 0, 0, 0, 0, 0, 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        tick();
        do_start();
        foreach (fresh[i]) send(fresh[i]);
        chk("fresh_latency", int'(out_valid), 1);
        check_record("fresh", 3, 3, 2, 2, 1, 0);
        accept();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_score_tracker.md
Name: cmp_score_tracker

Overview:
- Downstream consumer of the 2-bit magnitude comparator's gt/eq/lt flags.
- Tallies comparator results over a fixed-length frame of accepted samples and tracks the longest consecutive A>B run.
- Emits one result record per frame through a valid/ready handshake.
- Sits between the comparator output and the uo_out / uio_out reporting logic in the top-level wrapper.

Parameters:
- FRAME_LEN, 8: number of legal samples per frame; range 1..2^CNT_W-1.
- CNT_W, 4: width of all counters and count outputs.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  input  1  comparator sample present on gt/eq/lt.
- in_ready  output  1  tracker accepts a sample this cycle.
- gt  input  1  comparator A>B flag.
- eq  input  1  comparator A==B flag.
- lt  input  1  comparator A<B flag.
- out_valid  output  1  result record valid.
- out_ready  input  1  consumer accepts the record.
- gt_cnt  output  CNT_W  legal gt samples in the frame.
- eq_cnt  output  CNT_W  legal eq samples in the frame.
- lt_cnt  output  CNT_W  legal lt samples in the frame.
- max_gt_run  output  CNT_W  longest run of consecutive legal gt samples.
- verdict  output  2  00 tie, 01 A wins, 10 B wins, 11 never driven.
- bad_cnt  output  CNT_W  illegal (non-one-hot) samples in the frame; saturates at all-ones.
- busy  output  1  high in ACCUM or REPORT.

Behaviour:
- Reset: rst high at a clock edge forces IDLE. All counters, run register, and outputs clear to 0, including in_ready, out_valid and busy. Applies in every state; an in-progress frame or pending record is discarded.
- FSM states: IDLE, ACCUM, REPORT.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: clears all counters and the run register; next state ACCUM.
- ACCUM:
  - in_ready=1; start is ignored.
  - A sample is accepted when in_valid&&in_ready; counters update on that edge.
  - Legal sample means exactly one of gt/eq/lt is high.
  - gt: gt_cnt+1; run+1; max_gt_run <= max(max_gt_run, run+1).
  - eq or lt: the matching counter +1; run <= 0.
  - Illegal sample: bad_cnt+1 (saturating). No other counter or run change, and it does not count toward FRAME_LEN.
  - When the accepted sample makes gt_cnt+eq_cnt+lt_cnt == FRAME_LEN, next state is REPORT. out_valid rises the cycle after that acceptance.
- REPORT:
  - in_ready=0; out_valid=1.
  - All count outputs and verdict hold stable until accepted.
  - verdict: 01 if gt_cnt>lt_cnt, 10 if lt_cnt>gt_cnt, else 00. eq_cnt does not affect verdict.
  - out_valid&&out_ready: next state IDLE; out_valid drops the next cycle.
  - Count outputs keep their last values in IDLE until the next start.
  - start during REPORT is ignored, including in the handshake cycle. A new frame needs start while in IDLE, so there is at least 1 idle cycle between frames.
- Latency: the last accepted sample is at edge N; out_valid is high from cycle N+1.
- Counter arithmetic: unsigned CNT_W-bit. Legal counters cannot overflow because FRAME_LEN < 2^CNT_W.
- busy = (state != IDLE).
- Input-side backpressure: in_valid high while in_ready is low is not consumed. The upstream source must hold the sample.

Test Plan:
- Reset behaviour:
  - Stimulus: rst=1 for 2 cycles.
  - Response: all outputs 0, state IDLE.
  - Stimulus: in_valid=1 with gt=1 while in IDLE.
  - Response: in_ready=0 and no counts change.
- Mixed frame:
  - Stimulus: start, then gt,gt,gt,eq,gt,lt,gt,gt back-to-back.
  - Response: out_valid high the cycle after the 8th sample; gt_cnt=6, eq_cnt=1, lt_cnt=1, max_gt_run=3, verdict=01, bad_cnt=0.
- Tie and B-wins frames:
  - Stimulus: 8×eq.
  - Response: eq_cnt=8, max_gt_run=0, verdict=00.
  - Stimulus: next frame lt×5 then gt×3.
  - Response: lt_cnt=5, gt_cnt=3, max_gt_run=3, verdict=10.
- Illegal flags:
  - Stimulus: insert {gt,eq}=11 and all-zero samples mid-frame.
  - Response: bad_cnt=2; frame still ends after 8 legal samples; run unaffected across the bad samples.
- Handshake and backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in REPORT, and drive extra in_valid and start pulses.
  - Response: record stable, in_ready=0, starts ignored.
  - Stimulus: pulse out_ready for 1 cycle.
  - Response: IDLE next cycle.
- Reset mid-operation:
  - Stimulus: assert rst after 4 samples of a frame.
  - Response: counts 0, IDLE, no out_valid.
  - Stimulus: new start then a full frame.
  - Response: correct fresh counts with no residue.
